uart_word_tx_arbiter: RTL

- Shares one byte-wide UART transmitter among NREQ requesters; each requester submits 32-bit words.
- Grants requesters round-robin, latches the granted word and sends it as 4 bytes, MSB first, over a valid/ready byte interface.
- Sits between lab logic (message sources) and the UART TX serializer. The bench UART model rebuilds each word by shifting received bytes left, so MSB-first order makes it print the word as sent.

---
 rtl/uart_word_tx_arbiter_if.sv | 53 +++++
 rtl/uart_word_tx_arbiter.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_word_tx_arbiter_if.sv
// ---------------------------------------------------------------------------
// uart_word_tx_arbiter_if
//   Bundles the requester side and the byte-stream side of the word
//   transmitter arbiter.
//
//   Signals:
//     req       NREQ     per-requester word request, held until its gnt
//     req_data  32*NREQ  word of requester i at [32*i+31:32*i]
//     gnt       NREQ     one-hot, one-cycle pulse: word of that requester latched
//     tx_data   8        byte towards the UART serializer
//     tx_valid  1        tx_data valid
//     tx_ready  1        serializer accepts the byte on tx_valid && tx_ready
//     busy      1        high from grant until the inter-word gap has expired
//     cur_id    3        requester being served, holds its value when idle
//
//   Modports:
//     master  the arbiter itself
//     slave   requesters plus serializer (the environment)
// ---------------------------------------------------------------------------
interface uart_word_tx_arbiter_if #(
  parameter int NREQ = 4
);
  logic [NREQ-1:0]      req;
  logic [32*NREQ-1:0]   req_data;
  logic [NREQ-1:0]      gnt;
  logic [7:0]           tx_data;
  logic                 tx_valid;
  logic                 tx_ready;
  logic                 busy;
  logic [2:0]           cur_id;

  modport master (
    input  req,
    input  req_data,
    input  tx_ready,
    output gnt,
    output tx_data,
    output tx_valid,
    output busy,
    output cur_id
  );

  modport slave (
    output req,
    output req_data,
    output tx_ready,
    input  gnt,
    input  tx_data,
    input  tx_valid,
    input  busy,
    input  cur_id
  );
endinterface

// File: rtl/uart_word_tx_arbiter.sv
// ---------------------------------------------------------------------------
// uart_word_tx_arbiter
//   Shares one byte-wide UART transmitter between NREQ word sources.
//   Requesters are granted round-robin; the granted 32-bit word is latched
//   and sent as 4 bytes, MSB first, over a valid/ready byte interface,
//   followed by GAP idle cycles before the next arbitration.
//
//   Parameters:
//     NREQ   number of requesters (2..8)
//     BYTES  bytes per word, fixed at 4
//     GAP    idle cycles after each word (0..15)
//
//   Ports:
//     clk    system clock, rising edge
//     rst_n  asynchronous active-low reset; a word in flight is abandoned
//     bus    uart_word_tx_arbiter_if.master (req/req_data/gnt, byte stream,
//            busy, cur_id)
//
//   Timing:
//     edge G    : word latched, gnt pulse, busy=1, cur_id updated
//     edge G+1  : first byte presented (tx_valid=1)
//     last handshake edge H : tx_valid=0; busy falls at edge H+GAP
//     All outputs are registered; there is no combinational req->gnt path.
// ---------------------------------------------------------------------------
module uart_word_tx_arbiter #(
  parameter int NREQ  = 4,
  parameter int BYTES = 4,
  parameter int GAP   = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  uart_word_tx_arbiter_if.master bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  // Terminal values of the byte and gap counters.
  localparam logic [1:0] LAST_BYTE = 2'(BYTES - 1);
  localparam logic [3:0] GAP_LAST  = 4'((GAP > 0) ? GAP - 1 : 0);

  // Registered state and its next-state companions.
  state_t          state_q,    state_d;
  logic [2:0]      ptr_q,      ptr_d;       // round-robin start position
  logic [31:0]     shreg_q,    shreg_d;     // word in flight, MSB byte on top
  logic [1:0]      cnt_q,      cnt_d;       // bytes already accepted
  logic [3:0]      gap_q,      gap_d;       // idle cycles already spent
  logic [NREQ-1:0] gnt_q,      gnt_d;
  logic            tx_valid_q, tx_valid_d;
  logic [7:0]      tx_data_q,  tx_data_d;
  logic            busy_q,     busy_d;
  logic [2:0]      cur_id_q,   cur_id_d;

  // Arbitration helpers.
  logic [7:0]      req_pad;    // req widened so a 3-bit index always fits
  logic [3:0]      rr_sum;
  logic [2:0]      rr_idx;
  logic [2:0]      pick;
  logic            found;
  logic [31:0]     word_sel;

  // -------------------------------------------------------------------------
  // Round-robin pick: first requesting index at or after ptr_q, wrapping.
  // -------------------------------------------------------------------------
  always_comb begin
    req_pad = 8'(bus.req);
    rr_sum  = '0;
    rr_idx  = '0;
    pick    = '0;
    found   = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      rr_sum = {1'b0, ptr_q} + 4'(k);
      rr_idx = (rr_sum >= 4'(NREQ)) ? 3'(rr_sum - 4'(NREQ)) : 3'(rr_sum);
      if (!found && req_pad[rr_idx]) begin
        found = 1'b1;
        pick  = rr_idx;
      end
    end
  end

  // Word of the picked requester; only consumed on the grant edge.
  always_comb begin
    word_sel = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (pick == 3'(k)) begin
        word_sel = bus.req_data[32*k +: 32];
      end
    end
  end

  // -------------------------------------------------------------------------
  // Next-state and output logic.
  // -------------------------------------------------------------------------
  always_comb begin
    // NOTE: every variable gets a hold/default value before the case so that
    // no path leaves one unassigned, which would infer a latch.
    state_d    = state_q;
    ptr_d      = ptr_q;
    shreg_d    = shreg_q;
    cnt_d      = cnt_q;
    gap_d      = gap_q;
    gnt_d      = '0;                 // gnt is a single-cycle pulse
    tx_valid_d = tx_valid_q;
    tx_data_d  = tx_data_q;
    busy_d     = busy_q;
    cur_id_d   = cur_id_q;

    unique case (state_q)
      ST_IDLE: begin
        if (found) begin
          shreg_d  = word_sel;
          gnt_d    = NREQ'(1) << pick;
          cur_id_d = pick;
          busy_d   = 1'b1;
          ptr_d    = (pick == 3'(NREQ - 1)) ? 3'd0 : pick + 3'd1;
          cnt_d    = '0;
          state_d  = ST_SEND;
        end
      end

      ST_SEND: begin
        if (!tx_valid_q) begin
          // First cycle after the grant: present the top byte.
          tx_valid_d = 1'b1;
          tx_data_d  = shreg_q[31:24];
        end else if (bus.tx_ready) begin
          // Byte accepted: move the next one up. While tx_ready is low
          // nothing changes, so tx_data/tx_valid stay stable.
          shreg_d   = {shreg_q[23:0], 8'h00};
          tx_data_d = shreg_q[23:16];
          cnt_d     = cnt_q + 2'd1;
          if (cnt_q == LAST_BYTE) begin
            tx_valid_d = 1'b0;
            gap_d      = '0;
            if (GAP == 0) begin
              busy_d  = 1'b0;
              state_d = ST_IDLE;
            end else begin
              state_d = ST_GAP;
            end
          end
        end
      end

      ST_GAP: begin
        if (gap_q == GAP_LAST) begin
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end else begin
          gap_d = gap_q + 4'd1;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // State register.
  // -------------------------------------------------------------------------
  // NOTE: the shift register is an ordinary flop vector, not a memory, so it
  // is reset with everything else; that keeps tx_data defined after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      ptr_q      <= '0;
      shreg_q    <= '0;
      cnt_q      <= '0;
      gap_q      <= '0;
      gnt_q      <= '0;
      tx_valid_q <= 1'b0;
      tx_data_q  <= '0;
      busy_q     <= 1'b0;
      cur_id_q   <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      shreg_q    <= shreg_d;
      cnt_q      <= cnt_d;
      gap_q      <= gap_d;
      gnt_q      <= gnt_d;
      tx_valid_q <= tx_valid_d;
      tx_data_q  <= tx_data_d;
      busy_q     <= busy_d;
      cur_id_q   <= cur_id_d;
    end
  end

  assign bus.gnt      = gnt_q;
  assign bus.tx_valid = tx_valid_q;
  assign bus.tx_data  = tx_data_q;
  assign bus.busy     = busy_q;
  assign bus.cur_id   = cur_id_q;

endmodule
